// File: rtl/frame_serializer.sv
// frame_serializer: parallel-to-serial frame transmitter.
// Frame = start bit (0), DATA_WIDTH payload bits, optional parity bit, STOP_BITS stop bits (1).
// A one-deep holding buffer in front of the shift register allows back-to-back frames.
// Optional feature macro: PARITY_EN (adds the PARITY state and parity bit).
module frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_tick,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam bit PAR_INV = (PARITY_ODD != 0);
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    // Parity sense is meaningless without the parity bit.
    localparam bit unused_parity_odd = (PARITY_ODD != 0);
`endif

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_stop_cnt, w_stop_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_cur_bit;
    logic [DATA_WIDTH-1:0] w_shift_adv;

    assign ready      = ~r_buf_full;
    assign w_accept   = data_valid & ~r_buf_full;
    assign busy       = (r_state != S_IDLE);
    assign tx_out     = r_tx;
    assign frame_done = r_done;

    // Bit order: the outgoing bit always sits at one end of the shift register.
    assign w_cur_bit   = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];
    assign w_shift_adv = (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, r_shift[DATA_WIDTH-1:1]};

    // Holding buffer: filled on accept, emptied when the FSM loads the shift register.
    // Load needs a full buffer and accept needs an empty one, so they never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= p_data;
            r_buf_full <= 1'b1;
        end
    end

`ifdef PARITY_EN
    logic r_par;

    // Parity is fixed at load time from the payload entering the shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_par <= 1'b0;
        else if (w_load) r_par <= (^r_buf) ^ PAR_INV;
    end
`endif

    // State and line registers; tx_out is driven straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-line logic; everything advances only on bit_tick.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_stop_nxt  = r_stop_cnt;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        if (bit_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_buf_full) begin
                        w_load      = 1'b1;
                        w_shift_nxt = r_buf;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    w_tx_nxt    = w_cur_bit;
                    w_shift_nxt = w_shift_adv;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
                S_DATA: begin
                    if (r_cnt == LAST_BIT) begin
`ifdef PARITY_EN
                        w_tx_nxt    = r_par;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_stop_nxt  = 1'b0;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_tx_nxt    = w_cur_bit;
                        w_shift_nxt = w_shift_adv;
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    w_tx_nxt    = 1'b1;
                    w_stop_nxt  = 1'b0;
                    w_state_nxt = S_STOP;
                end
`endif
                S_STOP: begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_done_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                        w_stop_nxt = 1'b0;
                        if (r_buf_full) begin
                            // Next frame's start bit follows with no idle bit.
                            w_load      = 1'b1;
                            w_shift_nxt = r_buf;
                            w_tx_nxt    = 1'b0;
                            w_state_nxt = S_START;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_stop_nxt = r_stop_cnt + 1'b1;
                        w_tx_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            endcase
        end
    end

endmodule
